// File: rtl/fdct8_serial.sv
// ---------------------------------------------------------------------------
// fdct8_serial -- serial 8-point forward integer DCT (HEVC coefficients).
//
// Takes a block of 8 residual samples x[0..7] one per handshake, buffers
// them, then produces the 8 coefficients X[0..7] one per output handshake.
// Each coefficient is S = sum_n x[n]*c[k][n], rounded as (S + add) >>> shift.
// It serves as the row/column 1-D stage of an 8x8 forward transform.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      synchronous reset, active low
//   d_in       signed input sample x[n] (IN_W bits)
//   in_valid   d_in is valid
//   in_ready   block accepts d_in (registered)
//   add        unsigned rounding offset, sampled when a coefficient is loaded
//   shift      arithmetic right-shift amount, sampled with add
//   d_out      signed coefficient X[k] (OUT_W bits)
//   out_idx    k of the coefficient currently on d_out
//   out_valid  d_out is valid
//   out_ready  downstream accepts d_out
//
// Build option:
//   FDCT_SAT_EN  when defined, the shifted result is clamped to the signed
//                OUT_W range; otherwise the low OUT_W bits are kept (wrap).
// ---------------------------------------------------------------------------
module fdct8_serial #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 25,
    parameter int ACC_W = 36
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  d_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [24:0]      add,
    input  logic        [3:0]       shift,
    output logic signed [OUT_W-1:0] d_out,
    output logic        [2:0]       out_idx,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic {
        LOAD = 1'b0,
        CALC = 1'b1
    } state_t;

    // Coefficient matrix c[k][n]
    localparam int COEF [8][8] = '{
        '{64,  64,  64,  64,  64,  64,  64,  64},
        '{89,  75,  50,  18, -18, -50, -75, -89},
        '{83,  36, -36, -83, -83, -36,  36,  83},
        '{75, -18, -89, -50,  50,  89,  18, -75},
        '{64, -64, -64,  64,  64, -64, -64,  64},
        '{50, -89,  18,  75, -75, -18,  89, -50},
        '{36, -83,  83, -36, -36,  83, -83,  36},
        '{18, -50,  75, -89,  89, -75,  50, -18}
    };

    state_t                  state_reg;
    logic [2:0]              in_cnt_reg;
    logic [2:0]              k_reg;
    logic                    in_ready_reg;
    logic signed [OUT_W-1:0] d_out_reg;
    logic [2:0]              out_idx_reg;
    logic                    out_valid_reg;

    // Sample buffer; no reset needed, every entry is rewritten per block.
    logic signed [IN_W-1:0]  samp_reg [8];

    logic                    load_fire;
    logic                    emit_fire;
    logic signed [ACC_W-1:0] prod [8];
    logic signed [ACC_W-1:0] sum_acc;
    logic signed [ACC_W-1:0] rounded;
    logic signed [OUT_W-1:0] coef_next;

    assign in_ready  = in_ready_reg;
    assign d_out     = d_out_reg;
    assign out_idx   = out_idx_reg;
    assign out_valid = out_valid_reg;

    assign load_fire = (state_reg == LOAD) && in_valid && in_ready_reg;
    // A new coefficient may only replace d_out once the previous one is taken.
    assign emit_fire = (state_reg == CALC) && (!out_valid_reg || out_ready);

    always_ff @(posedge clk) begin
        if (load_fire) begin
            samp_reg[in_cnt_reg] <= d_in;
        end
    end

    // One product per tap, coefficient row selected by the current k.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tap
            assign prod[gi] = ACC_W'(samp_reg[gi]) * ACC_W'(COEF[k_reg][gi]);
        end
    endgenerate

    always_comb begin
        sum_acc = '0;
        for (int n = 0; n < 8; n++) begin
            sum_acc = sum_acc + prod[n];
        end
        rounded = sum_acc + $signed(ACC_W'(add));
    end

`ifdef FDCT_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    logic [ACC_W-OUT_W:0]    hi_bits;

    always_comb begin
        shifted   = rounded >>> shift;
        hi_bits   = shifted[ACC_W-1:OUT_W-1];
        coef_next = shifted[OUT_W-1:0];
        // Bits above the OUT_W sign bit must all match it, else clamp.
        if ((hi_bits != '0) && (hi_bits != '1)) begin
            coef_next = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                         : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        coef_next = OUT_W'(rounded >>> shift);
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= LOAD;
            in_cnt_reg    <= 3'd0;
            k_reg         <= 3'd0;
            in_ready_reg  <= 1'b0;
            d_out_reg     <= '0;
            out_idx_reg   <= 3'd0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    in_ready_reg <= 1'b1;
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                    if (load_fire) begin
                        if (in_cnt_reg == 3'd7) begin
                            in_cnt_reg   <= 3'd0;
                            k_reg        <= 3'd0;
                            in_ready_reg <= 1'b0;
                            state_reg    <= CALC;
                        end else begin
                            in_cnt_reg <= in_cnt_reg + 3'd1;
                        end
                    end
                end
                CALC: begin
                    if (emit_fire) begin
                        d_out_reg     <= coef_next;
                        out_idx_reg   <= k_reg;
                        out_valid_reg <= 1'b1;
                        k_reg         <= k_reg + 3'd1;
                        // Reopen input while X[7] is still on the output.
                        if (k_reg == 3'd7) begin
                            state_reg    <= LOAD;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdct8_serial.sv
// ---------------------------------------------------------------------------
// tb_fdct8_serial -- directed self-checking bench for fdct8_serial.
// Blocks of 8 samples are sent with hand-computed expected coefficients;
// each delivered coefficient is printed on its own line.
// ---------------------------------------------------------------------------
module tb_fdct8_serial;

    localparam int IN_W  = 25;
    localparam int OUT_W = 25;
    localparam int ACC_W = 36;

    typedef logic signed [IN_W-1:0] blk_t [8];
    typedef longint exp_t [8];

    logic                    clk = 1'b0;
    logic                    reset;
    logic signed [IN_W-1:0]  d_in;
    logic                    in_valid;
    logic                    in_ready;
    logic [24:0]             add;
    logic [3:0]              shift;
    logic signed [OUT_W-1:0] d_out;
    logic [2:0]              out_idx;
    logic                    out_valid;
    logic                    out_ready;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    longint q_data[$];
    int     q_idx[$];
    int     q_cyc[$];
    bit     calc_win = 1'b0;
    int     viol     = 0;

    fdct8_serial #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .d_in     (d_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .add      (add),
        .shift    (shift),
        .d_out    (d_out),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Output monitor, sampled mid-cycle; also flags in_ready seen during CALC.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(longint'(d_out));
            q_idx.push_back(int'(out_idx));
            q_cyc.push_back(cyc);
            $display("[TB] out k=%0d d_out=%0d cycle=%0d", out_idx, d_out, cyc);
        end
        if (calc_win) begin
            if (out_valid && out_idx == 3'd7) calc_win = 1'b0;
            else if (in_ready) viol++;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send_samples(input blk_t x, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            d_in     = x[i];
            w        = 0;
            @(negedge clk);
            while (!in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_idx.delete();
        q_cyc.delete();
    endtask

    task automatic run_block(input string tag, input blk_t x, input logic [24:0] a,
                             input logic [3:0] s, input exp_t e, input bit bp);
        int w;
        clear_q();
        add       = a;
        shift     = s;
        out_ready = 1'b1;
        viol      = 0;
        send_samples(x, 8);
        calc_win = 1'b1;
        // 8th sample just accepted: X[0] appears one edge later.
        check({tag, "_lat0_valid"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_lat1_valid"}, out_valid, 1);
        check({tag, "_lat1_idx"}, out_idx, 0);
        if (bp) begin
            w = 0;
            while (!(out_valid && out_idx == 3'd3) && w < 50) begin
                @(posedge clk);
                #1;
                w++;
            end
            out_ready = 1'b0;
            repeat (5) begin
                @(posedge clk);
                #1;
                check({tag, "_hold_idx"}, out_idx, 3);
                check({tag, "_hold_d"}, d_out, e[3]);
            end
            out_ready = 1'b1;
        end
        w = 0;
        while (q_data.size() < 8 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        check({tag, "_count"}, q_data.size(), 8);
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            check($sformatf("%s_X%0d", tag, i), q_data[i], e[i]);
            check($sformatf("%s_idx%0d", tag, i), q_idx[i], i);
        end
        if (!bp && q_cyc.size() == 8) check({tag, "_consec"}, q_cyc[7] - q_cyc[0], 7);
        check({tag, "_in_ready_calc"}, viol, 0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_once"}, q_data.size(), 8);
        check({tag, "_idle"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t ones, imp0, imp7, neg3, maxv, fives;
        exp_t e_dc, e_imp0, e_imp7, e_rnd, e_neg3, e_ov, e_sh15;
        int   w;

        ones  = '{1, 1, 1, 1, 1, 1, 1, 1};
        imp0  = '{2, 0, 0, 0, 0, 0, 0, 0};
        imp7  = '{0, 0, 0, 0, 0, 0, 0, -1};
        neg3  = '{-3, 0, 0, 0, 0, 0, 0, 0};
        maxv  = '{16777215, 16777215, 16777215, 16777215,
                  16777215, 16777215, 16777215, 16777215};
        fives = '{5, 5, 5, 5, 5, 5, 5, 5};

        e_dc   = '{512, 0, 0, 0, 0, 0, 0, 0};
        e_imp0 = '{128, 178, 166, 150, 128, 100, 72, 36};
        e_imp7 = '{-64, 89, -83, 75, -64, 50, -36, 18};
        e_rnd  = '{4, 0, 0, 0, 0, 0, 0, 0};
        e_neg3 = '{-48, -67, -63, -57, -48, -38, -27, -14};
        e_sh15 = '{262143, 0, 0, 0, 0, 0, 0, 0};
`ifdef FDCT_SAT_EN
        e_ov   = '{16777215, 0, 0, 0, 0, 0, 0, 0};
`else
        e_ov   = '{-512, 0, 0, 0, 0, 0, 0, 0};
`endif

        reset     = 1'b0;
        in_valid  = 1'b0;
        d_in      = '0;
        add       = '0;
        shift     = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_d_out", d_out, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", in_ready, 1);

        // Main function
        run_block("dc", ones, 25'd0, 4'd0, e_dc, 1'b0);
        run_block("imp0", imp0, 25'd0, 4'd0, e_imp0, 1'b0);
        run_block("imp7", imp7, 25'd0, 4'd0, e_imp7, 1'b0);
        run_block("rnd", ones, 25'd64, 4'd7, e_rnd, 1'b0);
        run_block("neg3", neg3, 25'd0, 4'd2, e_neg3, 1'b0);
        run_block("bp", ones, 25'd0, 4'd0, e_dc, 1'b1);

        // Reset mid-LOAD: partial block must be discarded
        send_samples(fives, 4);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rstload_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstload_rel_ready", in_ready, 1);
        run_block("rstload_dc", ones, 25'd0, 4'd0, e_dc, 1'b0);

        // Reset while an output is pending
        clear_q();
        add       = '0;
        shift     = '0;
        out_ready = 1'b0;
        send_samples(fives, 8);
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("rstcalc_pending", out_valid, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rstcalc_valid", out_valid, 0);
        check("rstcalc_d_out", d_out, 0);
        check("rstcalc_idx", out_idx, 0);
        calc_win  = 1'b0;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rstcalc_delivered", q_data.size(), 0);
        run_block("rstcalc_dc", ones, 25'd0, 4'd0, e_dc, 1'b0);

        // Boundaries: full-scale input, wrap/saturation and maximum shift
        run_block("ovf", maxv, 25'd0, 4'd0, e_ov, 1'b0);
        run_block("sh15", maxv, 25'd0, 4'd15, e_sh15, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
